// File: rtl/pkt_arb_pkg.sv
// Shared types and helpers for the packet-atomic round-robin arbiter.
// Module-level widths derive from each instance's own NUM_IN; *_DEF mirror the defaults.
package pkt_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int NUM_IN_DEF  = 4;
  localparam int DATA_W_DEF  = 512;
  localparam int EMPTY_W_DEF = 6;
  localparam int GRANT_W_DEF = $clog2(NUM_IN_DEF);

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[32]) begin
      return 32'hFFFF_FFFF;
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/pkt_rr_arbiter_avlstrm_if.sv
// Avalon-ST bundle carrying LANES parallel streams; slice i of each field belongs to lane i.
interface pkt_rr_arbiter_avlstrm_if #(
  parameter int LANES   = 1,
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6
) ();

  logic [LANES*DATA_W-1:0]  data;
  logic [LANES-1:0]         valid;
  logic [LANES-1:0]         sop;
  logic [LANES-1:0]         eop;
  logic [LANES*EMPTY_W-1:0] empty;
  logic [LANES-1:0]         ready;

  modport master (output data, valid, sop, eop, empty, input ready);
  modport slave  (input data, valid, sop, eop, empty, output ready);

endinterface

// File: rtl/pkt_rr_arbiter_avlstrm_rr_prio_sel.sv
// Round-robin priority selector: first set request strictly after 'last', wrapping.
// Requests above 'last' are placed in the low half of a double-width vector so they win.
module rr_prio_sel
  import pkt_arb_pkg::*;
#(
  parameter  int NUM_IN  = 4,
  localparam int GRANT_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0]  req,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] gnt_id,
  output logic               gnt_vld
);

  logic [NUM_IN-1:0]   mask_s;
  logic [2*NUM_IN-1:0] dbl_s;
  logic [GRANT_W:0]    idx_s;
  logic [GRANT_W:0]    wrap_s;
  logic                found_s;

  // mark the lanes that rank above the last winner
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      mask_s[i] = ((GRANT_W+1)'(i) > {1'b0, last});
    end
  end

  assign dbl_s = {req, req & mask_s};

  // lowest set bit of the double-width vector, folded back into lane range
  always_comb begin
    idx_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < 2*NUM_IN; i++) begin
      if (dbl_s[i] && !found_s) begin
        idx_s   = (GRANT_W+1)'(i);
        found_s = 1'b1;
      end else begin
        idx_s   = idx_s;
        found_s = found_s;
      end
    end
    if (idx_s >= (GRANT_W+1)'(NUM_IN)) begin
      wrap_s = idx_s - (GRANT_W+1)'(NUM_IN);
    end else begin
      wrap_s = idx_s;
    end
  end

  assign gnt_id  = wrap_s[GRANT_W-1:0];
  assign gnt_vld = |req;

endmodule

// File: rtl/pkt_rr_arbiter_avlstrm.sv
// Packet-atomic round-robin merge of NUM_IN Avalon-ST streams onto one registered output.
// A grant spans SOP..EOP; new packets only start while the downstream FIFO is not almost full.
module pkt_rr_arbiter_avlstrm
  import pkt_arb_pkg::*;
#(
  parameter  int NUM_IN  = 4,
  parameter  int DATA_W  = 512,
  parameter  int EMPTY_W = 6,
  localparam int GRANT_W = $clog2(NUM_IN)
) (
  input  logic                       clk,
  input  logic                       rst,
  pkt_rr_arbiter_avlstrm_if.slave    in_st,
  pkt_rr_arbiter_avlstrm_if.master   out_st,
  input  logic                       out_almost_full,
  output logic [GRANT_W-1:0]         grant_id,
  output logic [31:0]                pkt_cnt,
  output logic [31:0]                drop_cnt
);

  arb_state_t         state_r, state_nxt_s;
  logic [GRANT_W-1:0] grant_r, last_grant_r, sel_id_s;
  logic               sel_vld_s;
  logic [NUM_IN-1:0]  req_s, orphan_s, ready_s;
  logic [31:0]        orphan_num_s;
  logic               out_free_s, accept_s, accept_eop_s, grant_now_s;

  logic [DATA_W-1:0]  out_data_r;
  logic [EMPTY_W-1:0] out_empty_r;
  logic               out_valid_r, out_sop_r, out_eop_r;

  assign req_s      = in_st.valid & in_st.sop;
  assign out_free_s = !out_valid_r || out_st.ready[0];

  rr_prio_sel #(.NUM_IN(NUM_IN)) u_sel (
    .req     (req_s),
    .last    (last_grant_r),
    .gnt_id  (sel_id_s),
    .gnt_vld (sel_vld_s)
  );

  // next state, per-input ready and beat acceptance
  always_comb begin
    state_nxt_s  = state_r;
    ready_s      = '0;
    orphan_s     = '0;
    accept_s     = 1'b0;
    accept_eop_s = 1'b0;
    grant_now_s  = 1'b0;
    if (rst) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          // mid-packet beats with no owner are swallowed while arbitrating
          orphan_s = in_st.valid & ~in_st.sop;
          ready_s  = orphan_s;
          if (sel_vld_s && !out_almost_full) begin
            grant_now_s = 1'b1;
            state_nxt_s = XFER;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        XFER: begin
          ready_s[grant_r] = out_free_s;
          accept_s         = in_st.valid[grant_r] && out_free_s;
          accept_eop_s     = accept_s && in_st.eop[grant_r];
          if (accept_eop_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = XFER;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  assign in_st.ready = ready_s;

  // number of orphan beats discarded this cycle
  always_comb begin
    orphan_num_s = 32'd0;
    for (int i = 0; i < NUM_IN; i++) begin
      orphan_num_s = orphan_num_s + {31'd0, orphan_s[i]};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // current grant and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r      <= GRANT_W'(NUM_IN - 1);
      last_grant_r <= GRANT_W'(NUM_IN - 1);
    end else begin
      if (grant_now_s) begin
        grant_r <= sel_id_s;
      end else begin
        grant_r <= grant_r;
      end
      if (accept_eop_s) begin
        last_grant_r <= grant_r;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  // output register: loads on accept, drains on downstream ready, otherwise holds
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
      out_data_r  <= '0;
      out_empty_r <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_sop_r   <= in_st.sop[grant_r];
      out_eop_r   <= in_st.eop[grant_r];
      out_data_r  <= in_st.data[grant_r*DATA_W +: DATA_W];
      out_empty_r <= in_st.empty[grant_r*EMPTY_W +: EMPTY_W];
    end else if (out_st.ready[0]) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // forwarded-packet (wrapping) and dropped-beat (saturating) counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= 32'd0;
      drop_cnt <= 32'd0;
    end else begin
      if (out_valid_r && out_st.ready[0] && out_eop_r) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end else begin
        pkt_cnt <= pkt_cnt;
      end
      drop_cnt <= sat_add32(drop_cnt, orphan_num_s);
    end
  end

  assign out_st.data  = out_data_r;
  assign out_st.valid = out_valid_r;
  assign out_st.sop   = out_sop_r;
  assign out_st.eop   = out_eop_r;
  assign out_st.empty = out_empty_r;
  assign grant_id     = grant_r;

endmodule

// File: tb/tb_pkt_rr_arbiter_avlstrm.sv
// Bench for pkt_rr_arbiter_avlstrm: directed steps plus a randomized packet mix,
// scored against a packet-level round-robin model and per-beat timing rules.
module tb_pkt_rr_arbiter_avlstrm;

  localparam int NUM_IN  = 4;
  localparam int DATA_W  = 512;
  localparam int EMPTY_W = 6;
  localparam int GW      = $clog2(NUM_IN);

  typedef struct {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic               orphan;
  } beat_t;

  logic clk;
  logic rst;
  logic out_almost_full;
  logic [GW-1:0] grant_id;
  logic [31:0]   pkt_cnt;
  logic [31:0]   drop_cnt;

  pkt_rr_arbiter_avlstrm_if #(.LANES(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) in_if ();
  pkt_rr_arbiter_avlstrm_if #(.LANES(1), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) out_if ();

  pkt_rr_arbiter_avlstrm #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_st           (in_if.slave),
    .out_st          (out_if.master),
    .out_almost_full (out_almost_full),
    .grant_id        (grant_id),
    .pkt_cnt         (pkt_cnt),
    .drop_cnt        (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  beat_t src_q[NUM_IN][$];
  beat_t model_q[NUM_IN][$];
  beat_t exp_q[$];
  int    acc_q[$];
  int    model_last = NUM_IN - 1;
  int    exp_pkts = 0;
  int    exp_drops = 0;
  int    or_mode = 0;
  int    af_mode = 0;
  bit    gap_en = 1'b0;
  bit    or_tog = 1'b0;
  bit    spacing_en = 1'b0;
  int    last_sop = -1;
  bit    stall_prev = 1'b0;
  logic [575:0] held;

  task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int w = 0; w < DATA_W/32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic add_pkt(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data   = rand_data();
      b.sop    = (k == 0);
      b.eop    = (k == len - 1);
      b.empty  = EMPTY_W'($urandom);
      b.orphan = 1'b0;
      src_q[src].push_back(b);
      model_q[src].push_back(b);
    end
  endtask

  task automatic add_orphan(input int src);
    beat_t b;
    b.data   = rand_data();
    b.sop    = 1'b0;
    b.eop    = 1'($urandom);
    b.empty  = EMPTY_W'($urandom);
    b.orphan = 1'b1;
    src_q[src].push_back(b);
    exp_drops++;
  endtask

  // Next packet goes to the first pending input after the previous winner.
  task automatic refill();
    beat_t b;
    bit    done;
    int    idx;
    done = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = (model_last + k) % NUM_IN;
      if (!done && model_q[idx].size() > 0) begin
        do begin
          b = model_q[idx].pop_front();
          exp_q.push_back(b);
        end while (!b.eop && model_q[idx].size() > 0);
        model_last = idx;
        done = 1'b1;
      end
    end
  endtask

  function automatic bit busy();
    bit r;
    r = (exp_q.size() != 0) || (out_if.valid[0] === 1'b1);
    for (int i = 0; i < NUM_IN; i++) r |= (src_q[i].size() != 0) || (model_q[i].size() != 0);
    return r;
  endfunction

  task automatic cycle();
    logic [NUM_IN*DATA_W-1:0]  d;
    logic [NUM_IN-1:0]         v, s, e;
    logic [NUM_IN*EMPTY_W-1:0] em;
    logic [575:0]              cur;
    beat_t                     h, o;
    bit                        orph_head;
    d = '0; v = '0; s = '0; e = '0; em = '0; orph_head = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        v[i] = (h.sop || !gap_en) ? 1'b1 : ($urandom_range(0, 3) != 0);
        s[i] = h.sop;
        e[i] = h.eop;
        d[i*DATA_W +: DATA_W]   = h.data;
        em[i*EMPTY_W +: EMPTY_W] = h.empty;
        if (h.orphan) orph_head = 1'b1;
      end
    end
    in_if.data = d; in_if.valid = v; in_if.sop = s; in_if.eop = e; in_if.empty = em;
    case (or_mode)
      1: out_if.ready = 1'($urandom_range(0, 1));
      2: begin or_tog = ~or_tog; out_if.ready = or_tog; end
      default: out_if.ready = 1'b1;
    endcase
    out_almost_full = (af_mode == 1) ? 1'b1 : (af_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    @(negedge clk);
    if (!rst) begin
      cur = 576'({out_if.valid[0], out_if.sop[0], out_if.eop[0], out_if.empty, out_if.data});
      if (stall_prev) check("stall_hold", cur, held);
      if (out_if.valid[0] && !stall_prev) begin
        check("beat_has_source", 576'(acc_q.size() != 0), 576'(1));
        if (acc_q.size() != 0) check("latency", 576'(cyc), 576'(acc_q.pop_front() + 1));
      end
      if (out_if.valid[0] && !out_if.ready[0] && !orph_head)
        check("stall_in_ready", 576'(in_if.ready), 576'(0));
      if (out_if.valid[0] && out_if.ready[0]) begin
        if (exp_q.size() == 0) refill();
        check("beat_expected", 576'(exp_q.size() != 0), 576'(1));
        if (exp_q.size() != 0) begin
          o = exp_q.pop_front();
          check("beat", cur, 576'({1'b1, o.sop, o.eop, o.empty, o.data}));
          if (o.eop) exp_pkts++;
          if (o.sop && spacing_en) begin
            if (last_sop >= 0) check("pkt_spacing", 576'(cyc - last_sop), 576'(3));
            last_sop = cyc;
          end
        end
      end
      stall_prev = out_if.valid[0] && !out_if.ready[0];
      held = cur;
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_if.valid[i] && in_if.ready[i] && src_q[i].size() > 0) begin
          h = src_q[i].pop_front();
          if (!h.orphan) acc_q.push_back(cyc);
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy() && n < 3000) begin
      cycle();
      n++;
    end
    check({tag, "_timeout"}, 576'(busy()), 576'(0));
    check({tag, "_pkt_cnt"}, 576'(pkt_cnt), 576'(exp_pkts));
    check({tag, "_drop_cnt"}, 576'(drop_cnt), 576'(exp_drops));
  endtask

  initial begin
    // Reset with orphan-looking beats on every input: nothing may be accepted
    rst = 1'b1;
    out_almost_full = 1'b0;
    out_if.ready = 1'b1;
    in_if.data = '0; in_if.valid = '1; in_if.sop = '0; in_if.eop = '0; in_if.empty = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 576'(in_if.ready), 576'(0));
    check("rst_out_valid", 576'(out_if.valid), 576'(0));
    check("rst_out_flags", 576'({out_if.sop, out_if.eop, out_if.empty}), 576'(0));
    check("rst_out_data", 576'(out_if.data), 576'(0));
    check("rst_grant_id", 576'(grant_id), 576'(NUM_IN - 1));
    check("rst_counters", 576'({pkt_cnt, drop_cnt}), 576'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_if.valid = '0;

    // 1: single 3-beat packet from input 0
    add_pkt(0, 3);
    drain("t1");
    check("t1_grant", 576'(grant_id), 576'(0));

    // 2: all inputs back-to-back 2-beat packets, one arbitration cycle each
    for (int r = 0; r < 3; r++) for (int i = 0; i < NUM_IN; i++) add_pkt(i, 2);
    spacing_en = 1'b1;
    last_sop = -1;
    drain("t2");
    spacing_en = 1'b0;

    // 3: out_ready toggling mid-packet
    or_mode = 2;
    or_tog = 1'b0;
    add_pkt(3, 5);
    drain("t3");
    or_mode = 0;

    // 4: almost_full blocks the start, release grants input 1
    af_mode = 1;
    add_pkt(1, 2);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t4_no_ready", 576'(in_if.ready), 576'(0));
      check("t4_no_out", 576'(out_if.valid), 576'(0));
      check("t4_no_grant", 576'(grant_id), 576'(model_last));
    end
    af_mode = 0;
    cycle();
    check("t4_grant", 576'(grant_id), 576'(1));
    check("t4_ready", 576'(in_if.ready), 576'(4'b0010));
    drain("t4");

    // 5: orphan beats on input 2 are dropped, then a real packet follows
    for (int k = 0; k < 3; k++) add_orphan(2);
    add_pkt(2, 2);
    drain("t5");

    // Random mix: lengths 1..5, random ready/almost_full/mid-packet gaps
    or_mode = 1;
    af_mode = 2;
    gap_en = 1'b1;
    for (int p = 0; p < 40; p++) add_pkt($urandom_range(0, NUM_IN - 1), $urandom_range(1, 5));
    drain("rand");
    or_mode = 0;
    af_mode = 0;
    gap_en = 1'b0;

    // 6: reset mid-packet, then a clean packet from input 0
    add_pkt(1, 6);
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      src_q[i].delete();
      model_q[i].delete();
    end
    exp_q.delete();
    acc_q.delete();
    model_last = NUM_IN - 1;
    exp_pkts = 0;
    exp_drops = 0;
    stall_prev = 1'b0;
    check("t6_out_valid", 576'(out_if.valid), 576'(0));
    check("t6_counters", 576'({pkt_cnt, drop_cnt}), 576'(0));
    check("t6_grant_id", 576'(grant_id), 576'(NUM_IN - 1));
    add_pkt(0, 3);
    drain("t6");
    check("t6_grant", 576'(grant_id), 576'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
